// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - AHB-Lite master converting local commands into SINGLE/INCR bursts
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         MAX_BEATS = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [4:0]  cmd_beats,
    input  logic [31:0] wd_data,
    output logic        wd_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        done_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [5:0] MAX_B     = 6'(MAX_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [4:0]  rem_q, rem_d;
    logic        dph_q, dph_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        done_err_q, done_err_d;

    logic        accept_cmd;
    logic        cmd_bad;
    logic [11:0] span;
    logic [31:0] addr_inc;
    logic        beat_ok;
    logic        err_first;

    function automatic logic [2:0] burst_enc(input logic [4:0] beats);
        case (beats)
            5'd1:    return 3'd0;
            5'd4:    return 3'd3;
            5'd8:    return 3'd5;
            5'd16:   return 3'd7;
            default: return 3'd1;
        endcase
    endfunction

    // End offset of the burst within its 1KB page; must not exceed 1024
    assign span = {2'b00, cmd_addr[9:0]} + (12'(cmd_beats) << cmd_size[1:0]);

    assign cmd_bad = (cmd_size > 3'd2)
                   || (cmd_beats == 5'd0)
                   || ({1'b0, cmd_beats} > MAX_B)
                   || ((cmd_size == 3'd1) && cmd_addr[0])
                   || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00))
                   || (span > 12'd1024);

    assign cmd_ready  = (state_q == S_IDLE) && !done_q;
    assign accept_cmd = cmd_valid && cmd_ready;
    assign addr_inc   = 32'd1 << hsize_q[1:0];
    assign beat_ok    = HREADY && !HRESP;
    assign err_first  = HRESP && !HREADY;

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        rem_d      = rem_q;
        dph_d      = dph_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        wd_pop     = 1'b0;

        if (dph_q && !hwrite_q && beat_ok) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
        end
        // A completed data phase ends here unless a new address is accepted below
        if (HREADY) begin
            dph_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_cmd) begin
                    if (cmd_bad) begin
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        haddr_d  = cmd_addr;
                        htrans_d = TR_NONSEQ;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                        hburst_d = burst_enc(cmd_beats);
                        rem_d    = cmd_beats;
                        state_d  = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (beat_ok) begin
                    wd_pop = hwrite_q;
                    if (hwrite_q) begin
                        hwdata_d = wd_data;
                    end
                    rem_d = rem_q - 5'd1;
                    dph_d = 1'b1;
                    if (rem_q > 5'd1) begin
                        haddr_d  = haddr_q + addr_inc;
                        htrans_d = TR_SEQ;
                    end else begin
                        htrans_d = TR_IDLE;
                        state_d  = S_LAST;
                    end
                end else if (err_first) begin
                    htrans_d = TR_IDLE;
                    rem_d    = 5'd0;
                    state_d  = S_ERR;
                end
            end
            S_LAST: begin
                if (beat_ok) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (err_first) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            haddr_q    <= 32'd0;
            htrans_q   <= TR_IDLE;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'd0;
            hburst_q   <= 3'd0;
            hwdata_q   <= 32'd0;
            rem_q      <= 5'd0;
            dph_q      <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hburst_q   <= hburst_d;
            hwdata_q   <= hwdata_d;
            rem_q      <= rem_d;
            dph_q      <= dph_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HWDATA    = hwdata_q;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign done_err  = done_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - scoreboard bench for ahb_lite_master with a randomized AHB slave model
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [2:0]  cmd_size = 3'd0;
    logic [4:0]  cmd_beats = 5'd0;
    logic [31:0] wd_data = 32'd0;
    logic        wd_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        done_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [31:0] HRDATA = 32'd0;

    ahb_lite_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_beats(cmd_beats),
        .wd_data(wd_data), .wd_pop(wd_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    bit          exp_done[$];
    logic [31:0] wdat[16];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, n_done = 0;
    int pops_seen = 0, pops_base = 0;
    int err_beat = -1, fw_beat = -1, fw_n = 0;
    bit wait_en = 1'b0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [31:0] memv(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [2:0] burst_of(input int n);
        if (n == 1) return 3'd0;
        if (n == 4) return 3'd3;
        if (n == 8) return 3'd5;
        if (n == 16) return 3'd7;
        return 3'd1;
    endfunction

    always @(posedge HCLK) cyc <= cyc + 1;

    // Show-ahead write-data source: next unconsumed word of the current command
    always @(posedge HCLK) begin
        #1;
        wd_data = wdat[(pops_seen - pops_base) & 15];
    end

    // Slave: random/forced wait states and two-cycle ERROR on a chosen beat
    int          s_beat = 0, s_err = 0, s_fw = 0;
    bit          s_dph = 1'b0;
    logic [31:0] s_addr = 32'd0;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            s_dph = 1'b0; s_err = 0; HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            if (s_dph && s_beat == err_beat && s_err == 0) begin
                HREADY = 1'b0; HRESP = 1'b1; s_err = 1;
            end else if (s_err == 1) begin
                HREADY = 1'b1; HRESP = 1'b1; s_err = 2;
            end else begin
                HRESP = 1'b0;
                if (s_dph && s_beat == fw_beat && s_fw > 0) begin
                    HREADY = 1'b0; s_fw--;
                end else begin
                    HREADY = !(s_dph && wait_en && $urandom_range(3) == 0);
                end
                HRDATA = (s_dph && HREADY) ? memv(s_addr) : $urandom;
            end
            if (HREADY) begin
                s_dph  = HTRANS[1];
                s_addr = HADDR;
                if (HTRANS == 2'b10) begin
                    s_beat = 0; s_err = 0; s_fw = fw_n;
                end else if (HTRANS == 2'b11) begin
                    s_beat++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer, read beat or done
    bit          m_dph = 1'b0, m_wr = 1'b0, m_errpend = 1'b0, m_hold = 1'b0;
    logic [31:0] m_wdata = 32'd0, p_addr = 32'd0;
    logic [1:0]  p_trans = 2'b00;
    bus_t        mb;
    logic [31:0] me;
    bit          md, acc;
    always @(negedge HCLK) begin
        #2;
        if (!HRESETn) begin
            m_dph = 1'b0; m_errpend = 1'b0; m_hold = 1'b0;
        end else begin
            if (rd_valid) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 1'b0, rd_data, 32'd0);
                else begin
                    me = exp_rd.pop_front();
                    check("rd_data", rd_data == me, rd_data, me);
                end
            end
            if (done) begin
                done_cyc = cyc;
                n_done++;
                check("rd_drained_at_done", exp_rd.size() == 0, 32'(exp_rd.size()), 32'd0);
                if (exp_done.size() == 0) check("done_unexpected", 1'b0, 32'd1, 32'd0);
                else begin
                    md = exp_done.pop_front();
                    check("done_err", done_err == md, 32'(done_err), 32'(md));
                end
            end
            if (m_errpend) check("htrans_idle_after_err", HTRANS == 2'b00, 32'(HTRANS), 32'd0);
            else if (m_hold) begin
                check("hold_haddr", HADDR == p_addr, HADDR, p_addr);
                check("hold_htrans", HTRANS == p_trans, 32'(HTRANS), 32'(p_trans));
            end
            if (m_dph && m_wr && HREADY && !HRESP)
                check("hwdata", HWDATA == m_wdata, HWDATA, m_wdata);
            acc = HTRANS[1] && HREADY;
            if (acc || wd_pop)
                check("wd_pop", wd_pop == (acc && !HRESP && HWRITE), 32'(wd_pop), 32'(acc && !HRESP && HWRITE));
            if (acc) begin
                if (exp_bus.size() == 0) check("bus_unexpected", 1'b0, HADDR, 32'd0);
                else begin
                    mb = exp_bus.pop_front();
                    check("haddr", HADDR == mb.addr, HADDR, mb.addr);
                    check("htrans", HTRANS == mb.trans, 32'(HTRANS), 32'(mb.trans));
                    check("hctl", {HWRITE, HSIZE, HBURST} == {mb.wr, mb.size, mb.burst},
                          32'({HWRITE, HSIZE, HBURST}), 32'({mb.wr, mb.size, mb.burst}));
                    m_wdata = mb.wdata;
                end
            end
            if (HREADY) begin
                m_dph = acc; m_wr = HWRITE;
            end
            if (wd_pop) pops_seen++;
            m_errpend = HRESP && !HREADY;
            m_hold    = HTRANS != 2'b00 && !HREADY && !HRESP;
            p_addr    = HADDR;
            p_trans   = HTRANS;
        end
    end

    // Reference model: expected transfers, read data and completion status of one command
    task automatic model_cmd(input bit wr, input logic [31:0] addr, input int size, input int beats,
                             input int eb, input int fwb, input int fwn);
        bit   legal;
        int   nacc, nrd;
        bus_t b;
        legal = size <= 2 && beats >= 1 && beats <= 16
                && (addr & 32'((1 << size) - 1)) == 32'd0
                && ((addr & 32'h3FF) + 32'(beats << size)) <= 32'd1024;
        for (int i = 0; i < 16; i++) wdat[i] = $urandom;
        pops_base = pops_seen;
        err_beat  = legal ? eb : -1;
        fw_beat   = fwb;
        fw_n      = fwn;
        if (legal) begin
            nacc = (eb >= 0) ? eb + 1 : beats;
            nrd  = (eb >= 0) ? eb : beats;
            for (int i = 0; i < nacc; i++) begin
                b.addr  = addr + 32'(i << size);
                b.trans = (i == 0) ? 2'b10 : 2'b11;
                b.wr    = wr;
                b.size  = 3'(size);
                b.burst = burst_of(beats);
                b.wdata = wdat[i];
                exp_bus.push_back(b);
            end
            if (!wr) for (int i = 0; i < nrd; i++) exp_rd.push_back(memv(addr + 32'(i << size)));
        end
        exp_done.push_back(!legal || eb >= 0);
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input int size, input int beats);
        bit got = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_size = 3'(size); cmd_beats = 5'(beats);
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge HCLK); #1;
            if (cmd_ready) begin got = 1'b1; acc_cyc = cyc; end
        end
        if (!got) check("accept_timeout", 1'b0, 32'd0, 32'd1);
        @(posedge HCLK); #3;
        cmd_valid = 1'b0;
    endtask

    task automatic run(input bit wr, input logic [31:0] addr, input int size, input int beats,
                       input int eb, input int fwb, input int fwn, input int lat);
        bit fin = 1'b0;
        model_cmd(wr, addr, size, beats, eb, fwb, fwn);
        send_cmd(wr, addr, size, beats);
        for (int t = 0; t < 400 && !fin; t++) begin
            @(negedge HCLK); #3;
            if (exp_done.size() == 0) fin = 1'b1;
        end
        if (!fin) check("done_timeout", 1'b0, 32'd0, 32'd1);
        else if (lat >= 0) check("latency", done_cyc - acc_cyc == lat, 32'(done_cyc - acc_cyc), 32'(lat));
        check("bus_drained", exp_bus.size() == 0, 32'(exp_bus.size()), 32'd0);
        exp_bus.delete(); exp_rd.delete(); exp_done.delete();
        @(posedge HCLK); #3;
    endtask

    initial begin
        int          sz, bt, eb, nd;
        logic [31:0] a;
        bit          w;
        repeat (3) @(negedge HCLK);
        #2;
        check("rst_bus", {HTRANS, HADDR, HWDATA, HSIZE, HBURST, HWRITE, HMASTLOCK} == '0,
              32'({HTRANS, HSIZE, HBURST, HWRITE, HMASTLOCK}), 32'd0);
        check("rst_hprot", HPROT == 4'b0011, 32'(HPROT), 32'h3);
        check("rst_local", {cmd_ready, wd_pop, rd_valid, done, done_err} == 5'b10000,
              32'({cmd_ready, wd_pop, rd_valid, done, done_err}), 32'h10);
        check("rst_rd_data", rd_data == 32'd0, rd_data, 32'd0);
        @(posedge HCLK); #3;
        HRESETn = 1'b1;
        @(posedge HCLK); #3;

        run(1'b0, 32'h10,  2, 1, -1, -1, 0, 3);
        run(1'b1, 32'h100, 2, 4, -1, -1, 0, 6);
        run(1'b0, 32'h200, 2, 4, -1, 1, 2, 8);
        run(1'b0, 32'h300, 2, 8, 1, -1, 0, -1);
        run(1'b1, 32'h340, 1, 5, 3, -1, 0, -1);
        run(1'b0, 32'h3F8, 2, 4, -1, -1, 0, 1);
        run(1'b0, 32'h2,   2, 1, -1, -1, 0, 1);
        run(1'b1, 32'h40,  2, 0, -1, -1, 0, 1);
        run(1'b0, 32'h40,  3, 1, -1, -1, 0, 1);
        run(1'b0, 32'h3C0, 2, 16, -1, -1, 0, 18);

        model_cmd(1'b0, 32'h400, 2, 16, -1, -1, 0);
        send_cmd(1'b0, 32'h400, 2, 16);
        repeat (5) @(posedge HCLK);
        #3;
        nd = n_done;
        HRESETn = 1'b0;
        #1;
        check("rst_mid_htrans", HTRANS == 2'b00, 32'(HTRANS), 32'd0);
        check("rst_mid_cmd_ready", cmd_ready == 1'b1, 32'(cmd_ready), 32'd1);
        exp_bus.delete(); exp_rd.delete(); exp_done.delete();
        repeat (2) @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
        repeat (10) @(posedge HCLK);
        #3;
        check("no_done_after_reset", n_done == nd, 32'(n_done), 32'(nd));
        run(1'b1, 32'h80, 0, 3, -1, -1, 0, 5);

        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom_range(1));
            sz = $urandom_range(2);
            case ($urandom_range(9))
                0: bt = 1;
                1: bt = 4;
                2: bt = 8;
                3: bt = 16;
                default: bt = $urandom_range(16, 1);
            endcase
            a = ($urandom & 32'hFFFF) & ~32'((1 << sz) - 1);
            if ($urandom_range(11) == 0) begin
                case ($urandom_range(2))
                    0: sz = 3;
                    1: bt = 0;
                    default: a = a | 32'd1;
                endcase
            end
            eb = (bt > 0 && $urandom_range(5) == 0) ? $urandom_range(bt - 1) : -1;
            wait_en = 1'($urandom_range(1));
            run(w, a, sz, bt, eb, -1, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
